queue_serializer: RTL and testbench

// Drains the read end of a queue and shifts each word out one bit at a time in asynchronous serial frames:
//   - one start bit (0);
//   - DATA_BITS data bits, LSB first;
//   - one stop bit (1).

---
 rtl/queue_serializer.sv | 110 +++++++++++
 tb/tb_queue_serializer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/queue_serializer.sv
// Pops one word per frame from a registered-output queue and sends it as start/LSB-first data/stop.
// Queue empty or en_i low holds the line at mark in IDLE; an active frame always completes.
module queue_serializer #(
  parameter int DATA_BITS = 8,
  parameter int DIV_BITS  = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic [DIV_BITS-1:0]  baud_div_i,
  input  logic                 q_empty_i,
  input  logic [DATA_BITS-1:0] q_dat_i,
  output logic                 q_pop_o,
  output logic                 q_oe_o,
  output logic                 txd_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(DATA_BITS) + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;

  logic [2:0]           state;
  logic [DIV_BITS-1:0]  div_q;
  logic [DIV_BITS-1:0]  div_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nxt;
  logic                 txd_q;
  logic                 bit_end;

  assign bit_end   = (div_cnt == '0);
  assign shift_nxt = shift >> 1;

  // txd_q is loaded together with the state change, so the line level always matches the state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      div_q   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd_q <= 1'b1;
          if (en_i && !q_empty_i) begin
            state <= FETCH;
            div_q <= baud_div_i;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shift   <= q_dat_i;
          bit_cnt <= '0;
          div_cnt <= div_q;
          txd_q   <= 1'b0;
          state   <= START;
        end
        START: begin
          if (bit_end) begin
            div_cnt <= div_q;
            txd_q   <= shift[0];
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt - DIV_BITS'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= div_q;
            shift   <= shift_nxt;
            if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
              txd_q <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              txd_q   <= shift_nxt[0];
            end
          end else begin
            div_cnt <= div_cnt - DIV_BITS'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
          end else begin
            div_cnt <= div_cnt - DIV_BITS'(1);
          end
        end
        default: begin
          state <= IDLE;
          txd_q <= 1'b1;
        end
      endcase
    end
  end

  assign q_pop_o = (state == FETCH);
  assign q_oe_o  = (state == FETCH);
  assign busy_o  = (state != IDLE);
  assign txd_o   = txd_q;

endmodule

// File: tb/tb_queue_serializer.sv
// Directed plus randomized checks of queue_serializer against a frame-level line model and a behavioural queue.
module tb_queue_serializer;

  localparam int DB  = 8;
  localparam int DVB = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic [DVB-1:0] baud_div;
  logic           q_empty;
  logic [DB-1:0]  q_dat;
  logic           q_pop;
  logic           q_oe;
  logic           txd;
  logic           busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  queue_serializer #(.DATA_BITS(DB), .DIV_BITS(DVB)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .en_i       (en),
    .baud_div_i (baud_div),
    .q_empty_i  (q_empty),
    .q_dat_i    (q_dat),
    .q_pop_o    (q_pop),
    .q_oe_o     (q_oe),
    .txd_o      (txd),
    .busy_o     (busy)
  );

  // Behavioural queue with registered data output.
  logic [DB-1:0] mem [0:63];
  int rp = 0;
  int wp = 0;
  assign q_empty = (rp == wp);

  always @(posedge clk) begin
    if (q_oe)  q_dat <= mem[rp % 64];
    if (q_pop) rp <= rp + 1;
  end

  task automatic push(input logic [DB-1:0] v);
    mem[wp % 64] = v;
    wp = wp + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected line per sampled cycle: FETCH and LOAD at mark, then each frame bit held d+1 clocks,
  // then one IDLE mark before any following frame.
  task automatic run_check(input int n_frames, input int d, input int cycles,
                           input int en_off_at, input bit rand_div, input string tag);
    bit et[$];
    bit ep[$];
    bit eb[$];
    bit fb[$];
    int base;
    int busy_cnt;
    int pop_cnt;
    int exp_busy;
    logic [DB-1:0] w;
    base = rp;
    for (int f = 0; f < n_frames; f++) begin
      w = mem[(base + f) % 64];
      et.push_back(1'b1); ep.push_back(1'b1); eb.push_back(1'b1);
      et.push_back(1'b1); ep.push_back(1'b0); eb.push_back(1'b1);
      fb.delete();
      fb.push_back(1'b0);
      for (int b = 0; b < DB; b++) fb.push_back(w[b]);
      fb.push_back(1'b1);
      foreach (fb[i])
        for (int r = 0; r <= d; r++) begin
          et.push_back(fb[i]); ep.push_back(1'b0); eb.push_back(1'b1);
        end
      et.push_back(1'b1); ep.push_back(1'b0); eb.push_back(1'b0);
    end
    while (et.size() < cycles) begin
      et.push_back(1'b1); ep.push_back(1'b0); eb.push_back(1'b0);
    end
    exp_busy = n_frames * (2 + (DB + 2) * (d + 1));
    busy_cnt = 0;
    pop_cnt  = 0;
    baud_div = DVB'(d);
    en = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_txd"},  32'(txd),  32'(et[k]));
      check({tag, "_pop"},  32'(q_pop), 32'(ep[k]));
      check({tag, "_oe"},   32'(q_oe),  32'(ep[k]));
      check({tag, "_busy"}, 32'(busy), 32'(eb[k]));
      busy_cnt += int'(busy);
      pop_cnt  += int'(q_pop);
      if (rand_div) baud_div = DVB'($urandom_range(0, 7));
      if (k == en_off_at) en = 1'b0;
    end
    if (cycles >= exp_busy + n_frames) begin
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      check({tag, "_pops"},        32'(pop_cnt),  32'(n_frames));
      check({tag, "_rp"},          32'(rp),       32'(base + n_frames));
    end
  endtask

  initial begin
    int n;
    int d;
    int rp_hold;
    reset = 1'b1;
    en = 1'b0;
    baud_div = '0;

    // Reset state and idle behaviour with an empty queue
    @(posedge clk);
    @(negedge clk);
    check("rst_txd",  32'(txd),   32'd1);
    check("rst_busy", 32'(busy),  32'd0);
    check("rst_pop",  32'(q_pop), 32'd0);
    check("rst_oe",   32'(q_oe),  32'd0);
    reset = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("empty_pop", 32'(q_pop), 32'd0);
      check("empty_txd", 32'(txd),   32'd1);
    end

    push(8'h55);
    run_check(1, 0, 20, -1, 1'b0, "t2_55");

    push(8'hA5);
    run_check(1, 3, 50, -1, 1'b1, "t3_a5");

    push(8'h01);
    push(8'h80);
    run_check(2, 0, 32, -1, 1'b0, "t4_b2b");
    check("t4_empty", 32'(q_empty), 32'd1);

    // Disabled: queued words must stay put
    en = 1'b0;
    push(8'h3C);
    push(8'hC3);
    push(8'h96);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("t5_hold_pop", 32'(q_pop), 32'd0);
    end
    run_check(2, 0, 40, 18, 1'b0, "t5_en");
    check("t5_left", 32'(wp - rp), 32'd1);
    run_check(1, 0, 16, -1, 1'b0, "t5_drain");

    // Reset in the middle of the data bits
    push(8'hF0);
    run_check(1, 1, 9, -1, 1'b0, "t6_pre");
    rp_hold = rp;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_txd",  32'(txd),  32'd1);
    check("t6_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("t6_no_pop", 32'(q_pop), 32'd0);
      check("t6_idle",   32'(txd),   32'd1);
    end
    check("t6_rp", 32'(rp), 32'(rp_hold));
    push(8'(($urandom_range(0, 255))));
    run_check(1, 1, 30, -1, 1'b0, "t6_post");

    // Randomized words and divisors
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(1, 2);
      d = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) push(8'($urandom_range(0, 255)));
      run_check(n, d, n * (3 + (DB + 2) * (d + 1)) + 5, -1, (n == 1), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
